// File: rtl/lock_if.sv
// Keypad, comparator and actuator signals of the three-digit lock controller.
interface lock_if;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        key_clear;
    logic        prog_req;
    logic [11:0] cmp_a;
    logic [11:0] cmp_b;
    logic        cmp_eq;
    logic        unlocked;
    logic        alarm;
    logic        prog_mode;
    logic        fail;
    logic [1:0]  digit_cnt;

    modport master (
        output key_valid, key_digit, key_clear, prog_req, cmp_eq,
        input  cmp_a, cmp_b, unlocked, alarm, prog_mode, fail, digit_cnt
    );

    modport slave (
        input  key_valid, key_digit, key_clear, prog_req, cmp_eq,
        output cmp_a, cmp_b, unlocked, alarm, prog_mode, fail, digit_cnt
    );
endinterface

// File: rtl/lock_controller.sv
// Three-digit lock sequencer: digit collection, compare, unlock/lockout timing
// and reprogramming of the stored code.
module lock_controller #(
    parameter int          MAX_TRIES      = 3,
    parameter int          UNLOCK_CYCLES  = 500,
    parameter int          LOCKOUT_CYCLES = 1000,
    parameter logic [11:0] DEFAULT_CODE   = 12'h123
) (
    input  logic   clk,
    input  logic   rst_n,
    lock_if.slave  bus
);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, CHECK, OPEN, PROG, LOCKOUT} state_t;

    state_t      state_q, state_d;
    logic [11:0] entry_q, entry_d;
    logic [11:0] code_q, code_d;
    logic [3:0]  tries_q, tries_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        unlocked_q, unlocked_d;
    logic        alarm_q, alarm_d;
    logic        prog_mode_q, prog_mode_d;
    logic        fail_q, fail_d;
    logic        digit_ok;

    assign digit_ok = bus.key_valid && (bus.key_digit <= 4'd9);

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        code_d  = code_q;
        tries_d = tries_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        fail_d  = 1'b0;
        case (state_q)
            IDLE, PROG: begin
                if (bus.key_clear) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (digit_ok) begin
                    if (cnt_q == 2'd2) begin
                        // Count wraps to 0 here so it never reads 3.
                        cnt_d = '0;
                        if (state_q == IDLE) begin
                            entry_d = {entry_q[7:0], bus.key_digit};
                            state_d = CHECK;
                        end else begin
                            code_d  = {entry_q[7:0], bus.key_digit};
                            entry_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        entry_d = {entry_q[7:0], bus.key_digit};
                        cnt_d   = cnt_q + 2'd1;
                    end
                end
            end
            CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if (bus.cmp_eq) begin
                    tries_d = '0;
                    timer_d = TW'(UNLOCK_CYCLES);
                    state_d = OPEN;
                end else begin
                    fail_d = 1'b1;
                    if ((tries_q + 4'd1) == 4'(MAX_TRIES)) begin
                        tries_d = '0;
                        timer_d = TW'(LOCKOUT_CYCLES);
                        state_d = LOCKOUT;
                    end else begin
                        tries_d = tries_q + 4'd1;
                        state_d = IDLE;
                    end
                end
            end
            OPEN: begin
                if (bus.prog_req)
                    state_d = PROG;
                else if (timer_q == TW'(1))
                    state_d = IDLE;
                else
                    timer_d = timer_q - TW'(1);
            end
            LOCKOUT: begin
                if (timer_q == TW'(1))
                    state_d = IDLE;
                else
                    timer_d = timer_q - TW'(1);
            end
            default: state_d = IDLE;
        endcase
        unlocked_d  = (state_d == OPEN);
        alarm_d     = (state_d == LOCKOUT);
        prog_mode_d = (state_d == PROG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            code_q      <= DEFAULT_CODE;
            tries_q     <= '0;
            timer_q     <= '0;
            cnt_q       <= '0;
            unlocked_q  <= 1'b0;
            alarm_q     <= 1'b0;
            prog_mode_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            code_q      <= code_d;
            tries_q     <= tries_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            unlocked_q  <= unlocked_d;
            alarm_q     <= alarm_d;
            prog_mode_q <= prog_mode_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.cmp_a     = entry_q;
    assign bus.cmp_b     = code_q;
    assign bus.unlocked  = unlocked_q;
    assign bus.alarm     = alarm_q;
    assign bus.prog_mode = prog_mode_q;
    assign bus.fail      = fail_q;
    assign bus.digit_cnt = cnt_q;
endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with an outcome scoreboard and a small code/tries model.
module tb_lock_controller;
    localparam int U = 500;
    localparam int L = 1000;
    localparam int MAXT = 3;

    typedef enum int {R_OPEN, R_FAIL, R_LOCK} res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    lock_if ifc ();
    assign ifc.cmp_eq = (ifc.cmp_a == ifc.cmp_b);

    lock_controller #(.MAX_TRIES(MAXT), .UNLOCK_CYCLES(U), .LOCKOUT_CYCLES(L),
                      .DEFAULT_CODE(12'h123)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    always #5 clk = ~clk;

    res_t        sb_q[$];
    logic [11:0] code_m = 12'h123;
    int          tries_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        ifc.key_valid = 1'b1;
        ifc.key_digit = d;
        tick();
        ifc.key_valid = 1'b0;
        ifc.key_digit = 4'd0;
    endtask

    task automatic clear_pulse(input logic with_key);
        ifc.key_clear = 1'b1;
        ifc.key_valid = with_key;
        ifc.key_digit = 4'd7;
        tick();
        ifc.key_clear = 1'b0;
        ifc.key_valid = 1'b0;
        ifc.key_digit = 4'd0;
    endtask

    // Enters three digits, predicts the outcome, and checks the CHECK cycle.
    task automatic enter_code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [11:0] e;
        e = {a, b, c};
        if (e == code_m) begin
            sb_q.push_back(R_OPEN);
            tries_m = 0;
        end else if (tries_m + 1 == MAXT) begin
            sb_q.push_back(R_LOCK);
            tries_m = 0;
        end else begin
            sb_q.push_back(R_FAIL);
            tries_m++;
        end
        press(a);
        press(b);
        press(c);
        check("check_cmp_a", 32'(ifc.cmp_a), 32'(e));
        check("check_outs", 32'({ifc.unlocked, ifc.fail, ifc.alarm}), 32'd0);
        tick();
        $display("entry %03h -> expecting outcome %0d", e, sb_q[0]);
    endtask

    // mode 0: time the phase; mode 1: request programming while open; mode 2: leave it running.
    task automatic finish_outcome(input int mode);
        res_t r;
        int   cnt;
        logic [2:0] exp;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        r = sb_q.pop_front();
        exp = (r == R_OPEN) ? 3'b100 : (r == R_FAIL) ? 3'b010 : 3'b011;
        check("outcome", 32'({ifc.unlocked, ifc.fail, ifc.alarm}), 32'(exp));
        check("cnt_after", 32'(ifc.digit_cnt), 32'd0);
        if (r == R_FAIL) begin
            tick();
            check("fail_pulse_end", 32'(ifc.fail), 32'd0);
        end else if (r == R_OPEN && mode == 1) begin
            ifc.prog_req = 1'b1;
            tick();
            ifc.prog_req = 1'b0;
            check("prog_mode_rise", 32'({ifc.prog_mode, ifc.unlocked}), 32'b10);
        end else if (r == R_OPEN && mode == 0) begin
            cnt = 0;
            while (ifc.unlocked && cnt < 5000) begin
                ifc.key_valid = cnt[0];
                ifc.key_digit = 4'd4;
                ifc.key_clear = (cnt == 7);
                cnt++;
                tick();
            end
            ifc.key_valid = 1'b0;
            ifc.key_clear = 1'b0;
            check("unlock_len", 32'(cnt), 32'(U));
            check("open_keys_dropped", 32'({ifc.digit_cnt, ifc.cmp_a}), 32'd0);
        end else if (r == R_LOCK) begin
            tick();
            check("fail_pulse_end_lock", 32'(ifc.fail), 32'd0);
            cnt = 1;
            while (ifc.alarm && cnt < 5000) begin
                ifc.key_valid = cnt[0];
                ifc.key_digit = 4'd3;
                ifc.prog_req  = cnt[1];
                cnt++;
                tick();
            end
            ifc.key_valid = 1'b0;
            ifc.prog_req  = 1'b0;
            check("lockout_len", 32'(cnt), 32'(L));
            check("lock_keys_dropped", 32'({ifc.prog_mode, ifc.digit_cnt, ifc.cmp_a}), 32'd0);
        end
    endtask

    initial begin
        ifc.key_valid = 1'b0;
        ifc.key_digit = 4'd0;
        ifc.key_clear = 1'b0;
        ifc.prog_req  = 1'b0;
        #12;
        check("rst_outs", 32'({ifc.unlocked, ifc.alarm, ifc.prog_mode, ifc.fail, ifc.digit_cnt}), 32'd0);
        check("rst_cmp", 32'({ifc.cmp_a, ifc.cmp_b}), 32'h000123);
        rst_n = 1'b1;
        tick();

        // Default code unlocks.
        enter_code(4'd1, 4'd2, 4'd3);
        finish_outcome(0);
        check("cmp_b_default", 32'(ifc.cmp_b), 32'h123);

        // Three wrong attempts lead to lockout, then the correct code works.
        for (int i = 0; i < 3; i++) begin
            enter_code(4'd4, 4'd5, 4'd6);
            finish_outcome(0);
        end
        enter_code(4'd1, 4'd2, 4'd3);
        finish_outcome(0);

        // Clear discards a partial entry.
        press(4'd1);
        check("dc_1", 32'(ifc.digit_cnt), 32'd1);
        clear_pulse(1'b0);
        check("dc_clr", 32'({ifc.digit_cnt, ifc.cmp_a}), 32'd0);
        press(4'd1);
        check("dc_1b", 32'(ifc.digit_cnt), 32'd1);
        press(4'd2);
        check("dc_2", 32'(ifc.digit_cnt), 32'd2);
        enter_code_tail: begin
            sb_q.push_back(R_OPEN);
            tries_m = 0;
            press(4'd3);
            tick();
            finish_outcome(1);
        end
        // Programming aborted by clear keeps the code.
        press(4'd5);
        check("prog_dc", 32'(ifc.digit_cnt), 32'd1);
        clear_pulse(1'b0);
        check("prog_abort", 32'({ifc.prog_mode, ifc.cmp_b}), 32'h0123);

        // Invalid digit ignored; clear beats a simultaneous key.
        press(4'd1);
        press(4'hA);
        check("bad_digit", 32'({ifc.digit_cnt, ifc.cmp_a}), 32'h1001);
        clear_pulse(1'b1);
        check("clr_wins", 32'({ifc.digit_cnt, ifc.cmp_a}), 32'd0);
        enter_code(4'd1, 4'd2, 4'd3);
        finish_outcome(1);

        // Program a new code.
        press(4'd9);
        press(4'd8);
        press(4'd7);
        code_m = 12'h987;
        check("prog_done", 32'({ifc.prog_mode, ifc.digit_cnt, ifc.cmp_b}), 32'h0987);
        enter_code(4'd1, 4'd2, 4'd3);
        finish_outcome(0);
        enter_code(4'd9, 4'd8, 4'd7);
        finish_outcome(2);

        // Asynchronous reset mid-open restores everything.
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", 32'({ifc.unlocked, ifc.alarm, ifc.prog_mode, ifc.fail, ifc.digit_cnt}), 32'd0);
        check("rst_mid_code", 32'({ifc.cmp_a, ifc.cmp_b}), 32'h000123);
        tick();
        rst_n = 1'b1;
        code_m = 12'h123;
        tries_m = 0;
        tick();
        enter_code(4'd1, 4'd2, 4'd3);
        finish_outcome(0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lock_controller.md
# lock_controller

Sequencing controller for the three-digit lock datapath. Collects three BCD key digits into a 12-bit entry word and presents it with the stored 12-bit code to the external 12-bit equality comparator. Samples the comparator result and drives the unlock, lockout and code-programming behaviour. Sits between the keypad decoder and the comparator/actuator outputs.

## Interface

Parameters:
- `MAX_TRIES`, default 3: consecutive mismatches that trigger lockout (range 1-15).
- `UNLOCK_CYCLES`, default 500: cycles `unlocked` stays high per successful entry (≥1).
- `LOCKOUT_CYCLES`, default 1000: cycles `alarm` stays high (≥1).
- `DEFAULT_CODE`, default 12'h123: stored code after reset, 3 BCD digits, first digit in [11:8].

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `key_valid`  in  1: one-cycle strobe, `key_digit` valid.
- `key_digit`  in  4: BCD digit; values 10-15 are ignored.
- `key_clear`  in  1: discard partial entry; abort programming.
- `prog_req`  in  1: request to program a new code (honoured only in OPEN).
- `cmp_a`  out  12: entry word to comparator.
- `cmp_b`  out  12: stored code to comparator.
- `cmp_eq`  in  1: comparator result (combinational from `cmp_a`/`cmp_b`).
- `unlocked`  out  1: lock released.
- `alarm`  out  1: lockout active.
- `prog_mode`  out  1: collecting new code.
- `fail`  out  1: one-cycle pulse on wrong code.
- `digit_cnt`  out  2: digits collected in current entry (0-2).

## Operation

- States: IDLE, CHECK, OPEN, PROG, LOCKOUT. All state, counters and outputs are registered.
- Reset values: state IDLE; entry 0; code `DEFAULT_CODE`; tries 0; timer 0; all 1-bit outputs 0; `digit_cnt` 0.
- Digit accept, in IDLE or PROG only, when `key_valid` is high and `key_digit` ≤ 9:
  - entry <= {entry[7:0], key_digit};
  - `digit_cnt` increments.
- Third digit accept: in IDLE go to CHECK; in PROG write code <= {entry[7:0], key_digit}, clear entry, go to IDLE.
- `key_clear` in IDLE/PROG: entry and `digit_cnt` are zeroed. PROG returns to IDLE with code unchanged. `key_clear` has priority over a simultaneous `key_valid`. `tries` is not affected.
- CHECK lasts exactly 1 cycle. `cmp_a` holds the full entry and `cmp_eq` is sampled. Entry and `digit_cnt` are cleared on exit.
  - Match: tries <= 0; timer <= `UNLOCK_CYCLES`; go to OPEN.
  - Mismatch: `fail` pulses the next cycle.
    - If tries+1 == `MAX_TRIES`: tries <= 0; timer <= `LOCKOUT_CYCLES`; go to LOCKOUT.
    - Otherwise: tries <= tries+1; go to IDLE.
- OPEN: `unlocked` = 1.
  - If timer == 1, go to IDLE. Otherwise decrement the timer.
  - `prog_req` high: go to PROG; `unlocked` drops. `prog_req` wins over timer expiry in the same cycle.
  - Digits and `key_clear` are ignored.
- PROG: `prog_mode` = 1; no timeout.
- LOCKOUT: `alarm` = 1; all key inputs and `prog_req` are ignored. If timer == 1, go to IDLE; otherwise decrement.
- `prog_req` outside OPEN is ignored.
- `cmp_a` = entry at all times; `cmp_b` = code at all times.
- Reset asserted mid-operation immediately restores all reset values, including the code, which returns to `DEFAULT_CODE`.

## Timing

- Third digit accepted at edge N: CHECK during cycle N..N+1.
- Match: `unlocked` rises at edge N+1 and stays high exactly `UNLOCK_CYCLES` cycles.
- Mismatch: `fail` high for cycle N+1..N+2 only.
- Lockout: `alarm` rises at edge N+1 and stays high exactly `LOCKOUT_CYCLES` cycles. IDLE accepts digits from the edge after `alarm` falls.
- `prog_mode` rises on the edge after `prog_req` is sampled in OPEN. It falls on the edge that writes the code or sees `key_clear`.
- Keypresses during CHECK, OPEN and LOCKOUT are dropped, not buffered.
- `digit_cnt` never reads 3; it returns to 0 on the third accept edge in PROG and on CHECK exit.

## Test plan

- After reset, keys 1,2,3 -> CHECK one cycle later; `unlocked`=1 for exactly 500 cycles; `fail`, `alarm` stay 0; `cmp_b`=12'h123 throughout.
- Keys 4,5,6 three times -> `fail` pulses after the 1st and 2nd attempts. After the 3rd, `alarm`=1 for 1000 cycles with all keys ignored. Then 1,2,3 unlocks.
- Unlock, assert `prog_req`, keys 9,8,7 -> `cmp_b`=12'h987, state IDLE. Then 1,2,3 gives `fail`; 9,8,7 gives `unlocked`.
- Keys 1, `key_clear`, then 1,2,3 -> `digit_cnt` goes 1,0,1,2,0; unlock occurs. In PROG, keys 5,`key_clear` -> code remains 12'h123.
- Invalid digit 4'hA between keys 1 and 2 -> ignored, `digit_cnt` unchanged; 1,2,3 still unlocks. Simultaneous `key_valid`+`key_clear` -> clear wins.
- `rst_n` pulsed low mid-OPEN after reprogramming to 12'h987 -> all outputs 0 immediately; `cmp_b`=12'h123.
